// File: rtl/turn_scheduler_if.sv
// Board-side bundle between the button/player logic and turn_scheduler.
// master drives buttons, start and death pulses; slave is the scheduler.
interface turn_scheduler_if;
  logic       start;
  logic [3:0] btns;
  logic [1:0] player_dead;
  logic [3:0] btns_p0;
  logic [3:0] btns_p1;
  logic [1:0] playerDisable;
  logic [1:0] respawn;
  logic       active;
  logic [1:0] lives0;
  logic [1:0] lives1;
  logic [1:0] state;
  logic       game_over;
  logic       winner;
  logic       draw;

  modport master (
    output start, btns, player_dead,
    input  btns_p0, btns_p1, playerDisable, respawn,
    input  active, lives0, lives1, state,
    input  game_over, winner, draw
  );

  modport slave (
    input  start, btns, player_dead,
    output btns_p0, btns_p1, playerDisable, respawn,
    output active, lives0, lives1, state,
    output game_over, winner, draw
  );
endinterface

// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: game state, button routing, lives, winner.
// Define TURN_TIMEOUT_EN to force a hand-over after TURN_TICKS cycles.
module turn_scheduler #(
  parameter int TURN_TICKS    = 16,
  parameter int RESPAWN_TICKS = 8,
  parameter int LIVES         = 3
) (
  input logic             btnClk,
  input logic             rst,
  turn_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam int MAX_TICKS =
    (TURN_TICKS > RESPAWN_TICKS) ? TURN_TICKS : RESPAWN_TICKS;
  localparam int CW = $clog2(MAX_TICKS) + 1;

  localparam logic [CW-1:0] RSP_LAST   = CW'(RESPAWN_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  state_t        state_q, state_d;
  logic          active_q, active_d;
  logic [1:0]    lives0_q, lives0_d;
  logic [1:0]    lives1_q, lives1_d;
  logic [1:0]    dis_q, dis_d;
  logic [1:0]    rsp_q, rsp_d;
  logic          go_q, go_d;
  logic          win_q, win_d;
  logic          draw_q, draw_d;
  logic [1:0]    dead_q, dead_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

  logic          move;
  logic          timeout;
  logic [1:0]    nl0, nl1;
  logic          both_out, one_out;

`ifdef TURN_TIMEOUT_EN
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_TICKS - 1);

  logic [CW-1:0] turn_cnt_q, turn_cnt_d;

  assign timeout = (turn_cnt_q == TURN_LAST);

  // turn timer runs only while the same player keeps the turn in PLAY
  always_comb begin
    turn_cnt_d = '0;
    if (state_q == PLAY && state_d == PLAY && active_d == active_q)
      turn_cnt_d = turn_cnt_q + 1'b1;
  end

  // turn timer register
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) turn_cnt_q <= '0;
    else     turn_cnt_q <= turn_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // only single-direction presses count as a move
  always_comb begin
    move = 1'b0;
    unique case (bus.btns)
      4'h8, 4'h4, 4'h2, 4'h1: move = 1'b1;
      default:                move = 1'b0;
    endcase
  end

  // lives after this edge's death pulses, saturating at zero
  always_comb begin
    nl0 = lives0_q;
    nl1 = lives1_q;
    if (bus.player_dead[0] && lives0_q != 2'd0)
      nl0 = lives0_q - 2'd1;
    if (bus.player_dead[1] && lives1_q != 2'd0)
      nl1 = lives1_q - 2'd1;
    both_out = (nl0 == 2'd0) && (nl1 == 2'd0);
    one_out  = (nl0 == 2'd0) ^ (nl1 == 2'd0);
  end

  // next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    lives0_d  = lives0_q;
    lives1_d  = lives1_q;
    rsp_d     = 2'b00;
    win_d     = win_q;
    draw_d    = draw_q;
    dead_d    = dead_q;
    rsp_cnt_d = rsp_cnt_q;

    unique case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d  = PLAY;
          active_d = 1'b0;
          lives0_d = LIVES_INIT;
          lives1_d = LIVES_INIT;
          win_d    = 1'b0;
          draw_d   = 1'b0;
        end
      end
      PLAY: begin
        if (|bus.player_dead) begin
          lives0_d = nl0;
          lives1_d = nl1;
          unique case (1'b1)
            both_out: begin
              state_d = OVER;
              draw_d  = 1'b1;
              win_d   = 1'b0;
            end
            one_out: begin
              state_d = OVER;
              draw_d  = 1'b0;
              win_d   = (nl0 == 2'd0);
            end
            default: begin
              state_d   = RESPAWN;
              rsp_cnt_d = '0;
              rsp_d     = bus.player_dead;
              dead_d    = bus.player_dead;
            end
          endcase
        end else if (move || timeout) begin
          active_d = ~active_q;
        end
      end
      RESPAWN: begin
        if (rsp_cnt_q == RSP_LAST) begin
          state_d  = PLAY;
          active_d = (dead_q == 2'b10);
        end else begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
        end
      end
    endcase

    go_d  = (state_d == OVER);
    dis_d = 2'b11;
    if (state_d == PLAY)
      dis_d = active_d ? 2'b01 : 2'b10;
  end

  // state and output registers
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      lives0_q  <= 2'd0;
      lives1_q  <= 2'd0;
      dis_q     <= 2'b11;
      rsp_q     <= 2'b00;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
      draw_q    <= 1'b0;
      dead_q    <= 2'b00;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      lives0_q  <= lives0_d;
      lives1_q  <= lives1_d;
      dis_q     <= dis_d;
      rsp_q     <= rsp_d;
      go_q      <= go_d;
      win_q     <= win_d;
      draw_q    <= draw_d;
      dead_q    <= dead_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  assign bus.btns_p0 =
    (state_q == PLAY && !active_q) ? bus.btns : 4'h0;
  assign bus.btns_p1 =
    (state_q == PLAY && active_q) ? bus.btns : 4'h0;

  assign bus.playerDisable = dis_q;
  assign bus.respawn       = rsp_q;
  assign bus.active        = active_q;
  assign bus.lives0        = lives0_q;
  assign bus.lives1        = lives1_q;
  assign bus.state         = state_q;
  assign bus.game_over     = go_q;
  assign bus.winner        = win_q;
  assign bus.draw          = draw_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Vector-table bench for turn_scheduler with an expected-result queue.
// Timeout vectors follow TURN_TIMEOUT_EN to match the DUT build.
module tb_turn_scheduler;

  localparam int RT = 8;

  typedef struct {
    logic       start;
    logic [3:0] btns;
    logic [1:0] dead;
    logic [3:0] bp0;
    logic [3:0] bp1;
    logic [1:0] st;
    logic       act;
    logic [1:0] l0;
    logic [1:0] l1;
    logic [1:0] dis;
    logic [1:0] rsp;
    logic       go;
    logic       win;
    logic       dr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  turn_scheduler_if bus ();

  turn_scheduler #(
    .TURN_TICKS    (16),
    .RESPAWN_TICKS (RT),
    .LIVES         (3)
  ) dut (
    .btnClk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", nm, cur, act, exp);
    end
  endtask

  function automatic void add(
    input int st_in, input int bt, input int dd,
    input int bp0, input int bp1,
    input int s, input int a, input int l0, input int l1,
    input int dis, input int rsp,
    input int go, input int w, input int dr);
    vec_t v;
    v.start = 1'(st_in);
    v.btns  = 4'(bt);
    v.dead  = 2'(dd);
    v.bp0   = 4'(bp0);
    v.bp1   = 4'(bp1);
    v.st    = 2'(s);
    v.act   = 1'(a);
    v.l0    = 2'(l0);
    v.l1    = 2'(l1);
    v.dis   = 2'(dis);
    v.rsp   = 2'(rsp);
    v.go    = 1'(go);
    v.win   = 1'(w);
    v.dr    = 1'(dr);
    tbl.push_back(v);
  endfunction

  // RT-1 cycles held in RESPAWN (buttons pressed, not routed),
  // then the edge back into PLAY
  function automatic void rsp_seq(
    input int a_hold, input int a_exit,
    input int l0, input int l1, input int d_first);
    for (int i = 0; i < RT - 1; i++)
      add(0, 8, (i == 0) ? d_first : 0, 0, 0,
          2, a_hold, l0, l1, 3, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, a_exit, l0, l1,
        (a_exit != 0) ? 1 : 2, 0, 0, 0, 0);
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    bus.start       = v.start;
    bus.btns        = v.btns;
    bus.player_dead = v.dead;
    exp_q.push_back(v);
    #1;
    chk("btns_p0", int'(bus.btns_p0), int'(v.bp0));
    chk("btns_p1", int'(bus.btns_p1), int'(v.bp1));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state",   int'(bus.state),         int'(e.st));
    chk("active",  int'(bus.active),        int'(e.act));
    chk("lives0",  int'(bus.lives0),        int'(e.l0));
    chk("lives1",  int'(bus.lives1),        int'(e.l1));
    chk("disable", int'(bus.playerDisable), int'(e.dis));
    chk("respawn", int'(bus.respawn),       int'(e.rsp));
    chk("over",    int'(bus.game_over),     int'(e.go));
    chk("winner",  int'(bus.winner),        int'(e.win));
    chk("draw",    int'(bus.draw),          int'(e.dr));
  endtask

  initial begin
    // start, btns, dead | bp0, bp1 | st, act, l0, l1, dis, rsp, go, win, draw
    add(0, 0, 0,  0, 0,  0, 0, 0, 0, 3, 0, 0, 0, 0);
    add(1, 0, 0,  0, 0,  1, 0, 3, 3, 2, 0, 0, 0, 0);
    add(0, 8, 0,  8, 0,  1, 1, 3, 3, 1, 0, 0, 0, 0);
    add(0, 12, 0, 0, 12, 1, 1, 3, 3, 1, 0, 0, 0, 0);
    add(0, 3, 0,  0, 3,  1, 1, 3, 3, 1, 0, 0, 0, 0);
    add(0, 2, 0,  0, 2,  1, 0, 3, 3, 2, 0, 0, 0, 0);
    add(1, 0, 0,  0, 0,  1, 0, 3, 3, 2, 0, 0, 0, 0);
    add(0, 0, 2,  0, 0,  2, 0, 3, 2, 3, 2, 0, 0, 0);
    rsp_seq(0, 1, 3, 2, 1);
    add(0, 1, 0,  0, 1,  1, 0, 3, 2, 2, 0, 0, 0, 0);
    add(0, 8, 1,  8, 0,  2, 0, 2, 2, 3, 1, 0, 0, 0);
    rsp_seq(0, 0, 2, 2, 0);
    add(0, 0, 3,  0, 0,  2, 0, 1, 1, 3, 3, 0, 0, 0);
    rsp_seq(0, 0, 1, 1, 0);
    add(0, 0, 3,  0, 0,  3, 0, 0, 0, 3, 0, 1, 0, 1);
    add(0, 8, 1,  0, 0,  3, 0, 0, 0, 3, 0, 1, 0, 1);
    add(1, 0, 0,  0, 0,  1, 0, 3, 3, 2, 0, 0, 0, 0);
    add(0, 0, 1,  0, 0,  2, 0, 2, 3, 3, 1, 0, 0, 0);
    rsp_seq(0, 0, 2, 3, 0);
    add(0, 0, 1,  0, 0,  2, 0, 1, 3, 3, 1, 0, 0, 0);
    rsp_seq(0, 0, 1, 3, 0);
    add(0, 0, 1,  0, 0,  3, 0, 0, 3, 3, 0, 1, 1, 0);
    add(1, 0, 0,  0, 0,  1, 0, 3, 3, 2, 0, 0, 0, 0);
`ifdef TURN_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 0, 0, 1, (i == 15) ? 1 : 0, 3, 3,
          (i == 15) ? 1 : 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 12, 0, 0, 12, 1, 1, 3, 3, 1, 0, 0, 0, 0);
`else
    for (int i = 0; i < 20; i++)
      add(0, 0, 0, 0, 0, 1, 0, 3, 3, 2, 0, 0, 0, 0);
`endif

    bus.start       = 1'b0;
    bus.btns        = 4'h8;
    bus.player_dead = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   int'(bus.state),         0);
    chk("rst_active",  int'(bus.active),        0);
    chk("rst_lives0",  int'(bus.lives0),        0);
    chk("rst_lives1",  int'(bus.lives1),        0);
    chk("rst_disable", int'(bus.playerDisable), 3);
    chk("rst_respawn", int'(bus.respawn),       0);
    chk("rst_over",    int'(bus.game_over),     0);
    chk("rst_winner",  int'(bus.winner),        0);
    chk("rst_draw",    int'(bus.draw),          0);
    chk("rst_bp0",     int'(bus.btns_p0),       0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cur = i;
      run_vec(tbl[i]);
    end
    cur = -1;

    // reset while the respawn pulse is high
    bus.start       = 1'b0;
    bus.btns        = 4'h0;
    bus.player_dead = 2'b10;
    @(posedge clk);
    #1;
    bus.player_dead = 2'b00;
    chk("mid_state",   int'(bus.state),   2);
    chk("mid_respawn", int'(bus.respawn), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state",   int'(bus.state),         0);
    chk("arst_respawn", int'(bus.respawn),       0);
    chk("arst_lives0",  int'(bus.lives0),        0);
    chk("arst_lives1",  int'(bus.lives1),        0);
    chk("arst_disable", int'(bus.playerDisable), 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_respawn", int'(bus.respawn), 0);
      chk("post_state",   int'(bus.state),   0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Two-player turn sequencer sitting above the player rectangle instances in the game top level. It owns the game state (idle, play, respawn, game over) and routes the shared board button bus to exactly one player per turn. It drives each player's disable input, counts lives from the players' death pulses, issues respawn pulses, and declares the winner.

## Interface
- TURN_TICKS, 16, btnClk cycles per turn before forced hand-over; legal range 1..255.
- RESPAWN_TICKS, 8, btnClk cycles spent in RESPAWN; legal range 1..255.
- LIVES, 3, lives loaded per player at game start; legal range 1..3.

- btnClk  in  1  game tick clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each edge; starts or restarts a game.
- btns  in  4  shared board buttons {U,D,R,L} = {8,4,2,1}.
- player_dead  in  2  per-player death pulse, bit i = player i.
- btns_p0, btns_p1  out  4  per-player button bus.
- playerDisable  out  2  bit i high disables player i.
- respawn  out  2  one-cycle pulse, bit i re-places player i.
- active  out  1  index of the player holding the turn.
- lives0, lives1  out  2  remaining lives.
- state  out  2  IDLE=0, PLAY=1, RESPAWN=2, OVER=3.
- game_over  out  1  high while in OVER.
- winner  out  1  valid in OVER when draw=0.
- draw  out  1  high in OVER when both players lost their last life on the same edge.

## Operation
- All outputs are registered except btns_p0/btns_p1.
- btns_pi = btns when state==PLAY and active==i; otherwise 4'b0.
- An accepted move is btns ∈ {8,4,2,1} in PLAY. Any other non-zero value is ignored and does not end the turn.
- IDLE:
  - playerDisable=2'b11.
  - start=1 → PLAY, with active=0, turn_cnt=0, lives0=lives1=LIVES.
- PLAY:
  - playerDisable[active]=0; the other bit is 1.
  - turn_cnt increments each cycle.
  - The turn ends on an accepted move, or when turn_cnt==TURN_TICKS-1 (timeout).
  - On turn end: active toggles and turn_cnt=0 on the same edge.
- Death handling in PLAY:
  - player_dead is sampled for both players, active or not.
  - Each asserted bit decrements that player's lives on that edge. The decrement saturates at 0.
  - Death takes priority over turn end.
  - Both players dead with both at 1 life → OVER, draw=1, winner=0.
  - Exactly one player's lives reach 0 → OVER, winner = the other player, draw=0.
  - Otherwise → RESPAWN, rsp_cnt=0, respawn = the latched player_dead bits. respawn is high only on the first RESPAWN cycle.
- RESPAWN:
  - playerDisable=2'b11.
  - rsp_cnt counts up; at rsp_cnt==RESPAWN_TICKS-1 → PLAY.
  - active on re-entry = the player that died; if both died, active=0.
  - turn_cnt=0 on re-entry.
  - player_dead is ignored in RESPAWN.
- OVER:
  - playerDisable=2'b11 and game_over=1.
  - lives, winner and draw hold.
  - start=1 → PLAY, with lives reloaded to LIVES, active=0, draw=0, winner=0.
- start is ignored in PLAY and RESPAWN.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE.
  - active=0, turn_cnt=0, rsp_cnt=0.
  - lives0=lives1=0.
  - playerDisable=2'b11, respawn=0.
  - game_over=0, winner=0, draw=0.
- Reset asserted mid-RESPAWN suppresses any pending respawn pulse.
- start high at edge N → state=PLAY and lives loaded after edge N.
- btns_p* follow btns combinationally in the same cycle. The hand-over after an accepted move takes effect at the next edge, so each turn yields at most one routed move.
- Death pulse at edge N → lives updated and state=RESPAWN or OVER after edge N. respawn is high from edge N to edge N+1.
- RESPAWN lasts exactly RESPAWN_TICKS cycles.
- Without an accepted move, a PLAY turn lasts exactly TURN_TICKS cycles.

## Configuration
- TURN_TIMEOUT_EN:
  - Defined: the timeout hand-over is active as specified.
  - Undefined: there is no timeout. A turn ends only on an accepted move or a death. turn_cnt is held at 0, and TURN_TICKS is unused.

## Test plan
- Reset, then start=1 for one cycle → state=1, active=0, lives0=lives1=3, playerDisable=2'b10, btns_p1=0.
- In PLAY, active=0, btns=8 for one cycle → btns_p0=8 in that cycle; active=1 and playerDisable=2'b01 after the edge.
- With TURN_TIMEOUT_EN, no buttons → active toggles every 16 cycles. btns=4'b1100 leaves active unchanged.
- player_dead=2'b10 in PLAY → lives1=2, state=2, respawn=2'b10 for one cycle; after 8 cycles state=1, active=1.
- Both at 1 life, player_dead=2'b11 → state=3, game_over=1, draw=1. A subsequent start → state=1, lives 3/3.
- rst asserted mid-RESPAWN → state=0, respawn=0, lives 0/0 immediately.
